uart_rx_cfg: RTL and testbench

Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. It supports configurable data width, parity mode and stop-bit count, and includes an input synchroniser, start-bit glitch rejection, and parity/framing error reporting. It sits between the pad-side serial line and the byte-consuming logic, delivering one-cycle valid pulses with parallel data and status.

---
 rtl/uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, start-bit glitch rejection,
// optional parity, 1 or 2 stop bits. Define UART_RX_MAJORITY_VOTE_EN for 3-sample voting.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | line idle, waiting for rx_s low
// S_START     | counting to mid start bit, rejects glitches
// S_DATA      | sampling DATA_BITS data bits, LSB first
// S_PARITY    | sampling parity bit (only when PARITY_MODE != 0)
// S_STOP      | sampling STOP_BITS stop bits
// S_DONE      | one cycle; loads outputs and pulses rx_valid
// S_WAIT_IDLE | line still low after frame; wait for high before re-arming
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int START_TC = HALF + 1;
`else
    localparam int START_TC = HALF;
`endif
    localparam logic [CW-1:0] START_TC_V = CW'(START_TC);
    localparam logic [CW-1:0] BIT_TC_V   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_rx_cfg: CLKS_PER_BIT out of range 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_cfg: DATA_BITS out of range 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_IDLE
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        baud, baud_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 perr_i, perr_nxt;
    logic                 ferr_i, ferr_nxt;
    logic                 rx_m, rx_s;
    logic                 bit_val;
    logic                 baud_tc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decision edge sits one cycle past mid-bit, so the two history flops hold mid-1 and mid.
    logic rx_d1, rx_d2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign baud_tc = (baud == BIT_TC_V);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr_i  <= 1'b0;
            ferr_i  <= 1'b0;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            perr_i  <= perr_nxt;
            ferr_i  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        perr_nxt    = perr_i;
        ferr_nxt    = ferr_i;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    baud_nxt  = '0;
                end
            end
            S_START: begin
                if (baud == START_TC_V) begin
                    baud_nxt = '0;
                    if (!bit_val) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                        perr_nxt    = 1'b0;
                        ferr_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_nxt  = '0;
                    shift_nxt = {bit_val, shift[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    baud_nxt  = '0;
                    // Odd mode expects the XOR over data and parity to be 1, even mode 0.
                    perr_nxt  = ((^shift) ^ bit_val) != (PARITY_MODE == 1);
                    state_nxt = S_STOP;
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_nxt = '0;
                    if (!bit_val) begin
                        ferr_nxt = 1'b1;
                    end
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = S_DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                rx_data    <= shift;
                parity_err <= perr_i;
                frame_err  <= ferr_i;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receiver configurations driven by
// directed and random frames; a negedge monitor checks every rx_valid pulse.
module tb_uart_rx_cfg;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_EXTRA = 1;
`else
    localparam int VOTE_EXTRA = 0;
`endif

    typedef struct {
        int lane;
        int data;
        int perr;
        int ferr;
        int start_cyc;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;

    logic       v0, v1, v2;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       b0, b1, b2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .rx_valid(v0), .rx_data(d0),
        .parity_err(pe0), .frame_err(fe0), .busy(b0)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .rx_valid(v1), .rx_data(d1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(13), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .rx_valid(v2), .rx_data(d2),
        .parity_err(pe2), .frame_err(fe2), .busy(b2)
    );

    function automatic int cpb(input int l);
        return (l == 2) ? 13 : 16;
    endfunction

    function automatic int dbits(input int l);
        return (l == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(input int l);
        return (l == 0) ? 0 : ((l == 1) ? 2 : 1);
    endfunction

    function automatic int sbits(input int l);
        return (l == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one level for n clock edges; always returns 1 time unit after a posedge.
    task automatic drive_bit(input int l, input int v, input int n);
        rx_line[l] = v[0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    // glitch_bit >= 0 inverts that data bit for one cycle at the centre vote sample.
    task automatic send_frame(input int l, input int data, input bit bad_par,
                              input int bad_stop, input int gap, input int glitch_bit);
        int   c, d, p, s, w, pbit, bv;
        exp_t e;
        c = cpb(l);
        d = dbits(l);
        p = pmode(l);
        s = sbits(l);
        w = data & ((1 << d) - 1);
        pbit = $countones(w) % 2;
        if (p == 1) pbit = 1 - pbit;
        if (bad_par) pbit = 1 - pbit;
        e.lane      = l;
        e.data      = w;
        e.perr      = (p != 0 && bad_par) ? 1 : 0;
        e.ferr      = (bad_stop >= 0) ? 1 : 0;
        e.start_cyc = cyc;
        e.lat       = 5 + (c - 1) / 2 + c * (d + ((p != 0) ? 1 : 0) + s) + VOTE_EXTRA;
        exp_q.push_back(e);
        drive_bit(l, 0, c);
        for (int i = 0; i < d; i++) begin
            bv = (w >> i) & 1;
            if (i == glitch_bit) begin
                drive_bit(l, bv, 1 + (c - 1) / 2);
                drive_bit(l, 1 - bv, 1);
                drive_bit(l, bv, c - 2 - (c - 1) / 2);
            end else begin
                drive_bit(l, bv, c);
            end
        end
        if (p != 0) drive_bit(l, pbit, c);
        for (int j = 0; j < s; j++) drive_bit(l, (j == bad_stop) ? 0 : 1, c);
        if (gap > 0) drive_bit(l, 1, gap);
    endtask

    task automatic random_frames(input int l, input int n);
        int bad_stop, gap;
        bit bad_par;
        for (int k = 0; k < n; k++) begin
            bad_par  = (pmode(l) != 0) && ($urandom_range(0, 4) == 0);
            bad_stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, sbits(l) - 1)) : -1;
            gap      = (bad_stop >= 0) ? cpb(l) : int'($urandom_range(0, 2 * cpb(l)));
            send_frame(l, int'($urandom_range(0, 511)), bad_par, bad_stop, gap, -1);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if ((l == 0 && v0) || (l == 1 && v1) || (l == 2 && v2)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse lane=%0d actual=pulse expected=none (t=%0t)", l, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_lane", l, mon_e.lane);
                    chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
                    case (l)
                        0: begin
                            chk("rx_data", int'(d0), mon_e.data);
                            chk("parity_err", int'(pe0), mon_e.perr);
                            chk("frame_err", int'(fe0), mon_e.ferr);
                        end
                        1: begin
                            chk("rx_data", int'(d1), mon_e.data);
                            chk("parity_err", int'(pe1), mon_e.perr);
                            chk("frame_err", int'(fe1), mon_e.ferr);
                        end
                        default: begin
                            chk("rx_data", int'(d2), mon_e.data);
                            chk("parity_err", int'(pe2), mon_e.perr);
                            chk("frame_err", int'(fe2), mon_e.ferr);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rx_line = 3'b111;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_valid", int'(v0), 0);
        chk("reset_busy", int'(b0), 0);
        chk("reset_data", int'(d0), 0);
        chk("reset_perr", int'(pe1), 0);
        chk("reset_ferr", int'(fe2), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send_frame(0, 'hA5, 1'b0, -1, 16, -1);
        chk("busy_after_A5", int'(b0), 0);
        random_frames(0, 10);

        // Start-bit glitch shorter than half a bit
        drive_bit(0, 0, 5);
        chk("glitch_busy_hi", int'(b0), 1);
        drive_bit(0, 1, 7);
        chk("glitch_busy_lo", int'(b0), 0);
        drive_bit(0, 1, 16);

        // Bad stop bit followed by a long break
        send_frame(0, 'h55, 1'b0, 0, 0, -1);
        drive_bit(0, 0, 40 * 16);
        chk("break_pending", exp_q.size(), 0);
        chk("break_busy_hi", int'(b0), 1);
        drive_bit(0, 1, 4);
        chk("break_busy_lo", int'(b0), 0);
        drive_bit(0, 1, 16);
        send_frame(0, 'h12, 1'b0, -1, 16, -1);

        // Reset during the 4th data bit of a frame
        drive_bit(0, 0, 16);
        drive_bit(0, 1, 16);
        drive_bit(0, 1, 16);
        drive_bit(0, 0, 16);
        drive_bit(0, 0, 8);
        rst_n   = 1'b0;
        rx_line = 3'b111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", int'(b0), 0);
        chk("abort_data", int'(d0), 0);
        chk("abort_valid", int'(v0), 0);
        drive_bit(0, 1, 16);
        send_frame(0, 'hC3, 1'b0, -1, 16, -1);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(0, 'hC3, 1'b0, -1, 16, 2);
`endif

        send_frame(1, 'h3C, 1'b1, -1, 16, -1);
        send_frame(1, 'h3C, 1'b0, -1, 16, -1);
        random_frames(1, 10);

        send_frame(2, 'h7F, 1'b0, -1, 0, -1);
        send_frame(2, 'h01, 1'b0, -1, 13, -1);
        random_frames(2, 10);

        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
        chk("pending_at_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
